// File: rtl/match_controller.sv
// match_controller: match flow FSM - start, round result hold, scoring, match end, restart.
module match_controller #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_FRAMES = 120,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_local,
    input  logic               btn_remote,
    input  logic               winner_valid,
    input  logic [1:0]         winner_code,
    output logic               game_rst,
    output logic               game_run,
    output logic [1:0]         state,
    output logic [1:0]         last_result,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         match_winner
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, RESULT = 2'b10, OVER = 2'b11} state_t;

    localparam int TW = $clog2(HOLD_FRAMES + 1);
    localparam logic [TW-1:0]      HOLD      = TW'(HOLD_FRAMES);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q, state_d;
    logic               prev_l_q, prev_l_d, prev_r_q, prev_r_d;
    logic               blk_l_q, blk_l_d, blk_r_q, blk_r_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [1:0]         last_q, last_d, winner_q, winner_d;
    logic               game_rst_q, game_rst_d, game_run_q, game_run_d;
    logic               start;

    // A button held through reset stays blocked until it is seen released, so it cannot fake an edge.
    assign start = (btn_local & ~prev_l_q & ~blk_l_q) | (btn_remote & ~prev_r_q & ~blk_r_q);

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_l_q   <= 1'b0;
            prev_r_q   <= 1'b0;
            blk_l_q    <= 1'b1;
            blk_r_q    <= 1'b1;
            timer_q    <= '0;
            score1_q   <= '0;
            score2_q   <= '0;
            last_q     <= 2'b00;
            winner_q   <= 2'b00;
            game_rst_q <= 1'b0;
            game_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_l_q   <= prev_l_d;
            prev_r_q   <= prev_r_d;
            blk_l_q    <= blk_l_d;
            blk_r_q    <= blk_r_d;
            timer_q    <= timer_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            last_q     <= last_d;
            winner_q   <= winner_d;
            game_rst_q <= game_rst_d;
            game_run_q <= game_run_d;
        end
    end

    // Next-state, scoring and registered-output logic
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        score1_d = score1_q;
        score2_d = score2_q;
        last_d   = last_q;
        winner_d = winner_q;
        prev_l_d = btn_local;
        prev_r_d = btn_remote;
        blk_l_d  = blk_l_q & btn_local;
        blk_r_d  = blk_r_q & btn_remote;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    score1_d = '0;
                    score2_d = '0;
                    last_d   = 2'b00;
                    winner_d = 2'b00;
                end
            end
            PLAY: begin
                // A verdict landing with game_rst still high belongs to the previous round.
                if (winner_valid && winner_code != 2'b00 && !game_rst_q) begin
                    state_d  = RESULT;
                    last_d   = winner_code;
                    timer_d  = HOLD;
                    score1_d = (winner_code == 2'b01 && score1_q != SCORE_MAX) ? score1_q + SCORE_W'(1) : score1_q;
                    score2_d = (winner_code == 2'b10 && score2_q != SCORE_MAX) ? score2_q + SCORE_W'(1) : score2_q;
                end
            end
            default: begin
                if (frame_tick) begin
                    if (timer_q <= TW'(1)) begin
                        timer_d  = '0;
                        state_d  = (score1_q >= WIN || score2_q >= WIN) ? OVER : PLAY;
                        winner_d = (score1_q >= WIN) ? 2'b01 : (score2_q >= WIN) ? 2'b10 : 2'b00;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
        endcase
        game_rst_d = (state_d == PLAY) && (state_q != PLAY);
        game_run_d = (state_d == PLAY);
    end

    assign game_rst     = game_rst_q;
    assign game_run     = game_run_q;
    assign state        = state_q;
    assign last_result  = last_q;
    assign score1       = score1_q;
    assign score2       = score2_q;
    assign match_winner = winner_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed scoreboard bench for the match flow controller.
module tb_match_controller;
    localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01, S_RES = 2'b10, S_OVER = 2'b11;

    logic       clk, rst, frame_tick, btn_local, btn_remote, winner_valid;
    logic [1:0] winner_code;
    logic       game_rst, game_run;
    logic [1:0] state, last_result, match_winner;
    logic [3:0] score1, score2;

    typedef struct {
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [1:0] lr;
        logic [1:0] mw;
        logic       gr;
    } exp_t;

    exp_t  q[$];
    string tq[$];
    int    n_cmp = 0;
    int    n_err = 0;

    match_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_local(btn_local),
        .btn_remote(btn_remote), .winner_valid(winner_valid), .winner_code(winner_code),
        .game_rst(game_rst), .game_run(game_run), .state(state), .last_result(last_result),
        .score1(score1), .score2(score2), .match_winner(match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] ex);
        n_cmp++;
        assert (obs === ex) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [1:0] lr, input logic [1:0] mw, input logic gr);
        exp_t e;
        e.st = st; e.s1 = s1; e.s2 = s2; e.lr = lr; e.mw = mw; e.gr = gr;
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (q.size() > 0) begin
            e = q.pop_front();
            t = tq.pop_front();
            chk({t, ".state"},        8'(state),        8'(e.st));
            chk({t, ".score1"},       8'(score1),       8'(e.s1));
            chk({t, ".score2"},       8'(score2),       8'(e.s2));
            chk({t, ".last_result"},  8'(last_result),  8'(e.lr));
            chk({t, ".match_winner"}, 8'(match_winner), 8'(e.mw));
            chk({t, ".game_rst"},     8'(game_rst),     8'(e.gr));
            chk({t, ".game_run"},     8'(game_run),     8'(e.st == S_PLAY));
        end
    endtask

    task automatic verdict(input logic [1:0] c);
        winner_valid = 1'b1;
        winner_code  = c;
        cyc();
        winner_valid = 1'b0;
        winner_code  = 2'b00;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; btn_local = 1'b0; btn_remote = 1'b0; frame_tick = 1'b0;
        winner_valid = 1'b0; winner_code = 2'b00;
        #3;
        push("reset", S_IDLE, 0, 0, 0, 0, 0); drain();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        // verdict while IDLE is dropped
        winner_valid = 1'b1; winner_code = 2'b01;
        push("idle_verdict", S_IDLE, 0, 0, 0, 0, 0); cyc(); drain();
        winner_valid = 1'b0;
        // start from local button
        btn_local = 1'b1;
        push("start", S_PLAY, 0, 0, 0, 0, 1); cyc(); drain();
        // verdict coincident with game_rst is stale
        winner_valid = 1'b1; winner_code = 2'b01;
        push("stale_verdict", S_PLAY, 0, 0, 0, 0, 0); cyc(); drain();
        btn_local = 1'b0; winner_code = 2'b00;
        push("code00", S_PLAY, 0, 0, 0, 0, 0); cyc(); drain();
        winner_valid = 1'b0;
        // P1 wins a round
        push("p1_win", S_RES, 1, 0, 2'b01, 0, 0); verdict(2'b01); drain();
        winner_valid = 1'b1; winner_code = 2'b10; btn_local = 1'b1;
        push("result_ignore", S_RES, 1, 0, 2'b01, 0, 0); cyc(); drain();
        winner_valid = 1'b0; winner_code = 2'b00; btn_local = 1'b0;
        cyc();
        push("hold119", S_RES, 1, 0, 2'b01, 0, 0); hold(119); drain();
        push("next_round", S_PLAY, 1, 0, 2'b01, 0, 1); tick(); drain();
        push("next_round_b", S_PLAY, 1, 0, 2'b01, 0, 0); cyc(); drain();
        // draw
        push("draw", S_RES, 1, 0, 2'b11, 0, 0); verdict(2'b11); drain();
        hold(119);
        push("after_draw", S_PLAY, 1, 0, 2'b11, 0, 1); tick(); drain();
        cyc();
        // three P2 rounds take the match
        for (int k = 1; k <= 3; k++) begin
            push("p2_win", S_RES, 1, 4'(k), 2'b10, 0, 0); verdict(2'b10); drain();
            hold(119);
            if (k < 3) push("p2_next", S_PLAY, 1, 4'(k), 2'b10, 0, 1);
            else push("match_over", S_OVER, 1, 3, 2'b10, 2'b10, 0);
            tick(); drain();
            cyc();
        end
        winner_valid = 1'b1; winner_code = 2'b01;
        push("over_verdict", S_OVER, 1, 3, 2'b10, 2'b10, 0); cyc(); drain();
        // both buttons plus a verdict in OVER: one start, verdict dropped
        btn_remote = 1'b1; btn_local = 1'b1;
        push("restart", S_PLAY, 0, 0, 0, 0, 1); cyc(); drain();
        winner_valid = 1'b0; winner_code = 2'b00;
        push("restart_b", S_PLAY, 0, 0, 0, 0, 0); cyc(); drain();
        btn_remote = 1'b0; btn_local = 1'b0;
        // reset mid-hold with a button held through it
        push("p1_b", S_RES, 1, 0, 2'b01, 0, 0); verdict(2'b01); drain();
        hold(70);
        btn_local = 1'b1; rst = 1'b1;
        #1;
        push("async_rst", S_IDLE, 0, 0, 0, 0, 0); drain();
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        push("held_btn", S_IDLE, 0, 0, 0, 0, 0); drain();
        btn_local = 1'b0;
        cyc();
        btn_local = 1'b1;
        push("repress", S_PLAY, 0, 0, 0, 0, 1); cyc(); drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
